line_buffer_out: RTL

- Double-buffered (ping-pong) scanline buffer between the layer renderer/mixer and the video output.
- Renderer writes pixels for line N+1 while line N is read out in step with the video timing counters.
- Read side clears each pixel after reading it, so every line starts transparent.
- Emits a per-line render request carrying the next line number.

---
 rtl/line_buffer_out_pkg.sv | 28 ++
 rtl/line_buffer_out_ram.sv | 36 +++
 rtl/line_buffer_out.sv | 138 +++++++++++++
 3 files changed

// File: rtl/line_buffer_out_pkg.sv
// Shared video definitions for the scanline output buffer: timing constants,
// pixel type, control state encoding and the next-render-line helper.
package line_buffer_out_pkg;

  localparam int H_ACTIVE = 320;
  localparam int H_TOTAL  = 424;
  localparam int V_ACTIVE = 224;
  localparam int V_TOTAL  = 262;
  localparam int PIX_W    = 15;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Line that the write bank will hold once the counters advance past the
  // current swap: two lines ahead of v, wrapping at the last frame line.
  function automatic logic [8:0] line_after_next(input logic [8:0] v,
                                                 input logic [8:0] v_last);
    if (v >= v_last - 9'd1) begin
      return v - (v_last - 9'd1);
    end
    return v + 9'd2;
  endfunction

endpackage

// File: rtl/line_buffer_out_ram.sv
// One scanline bank: port A is read-before-write (used for read-then-clear),
// port B is write-only (renderer writes and power-up clearing).
module line_ram #(
  parameter int DEPTH = 320,
  parameter int DW    = 15,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata
);

  logic [DW-1:0] mem [DEPTH];

  // Both ports share one clock; the top never points them at the same cell.
  // NOTE: the array has no reset branch so it maps onto block RAM; the INIT
  // sweep in the top is what gives it known contents.
  always_ff @(posedge clk) begin
    if (a_en) begin
      a_rdata <= mem[a_addr];
      if (a_we) begin
        mem[a_addr] <= a_wdata;
      end
    end
    if (b_we) begin
      mem[b_addr] <= b_wdata;
    end
  end

endmodule

// File: rtl/line_buffer_out.sv
// Ping-pong scanline buffer: the renderer fills one bank while the other is
// streamed to video and cleared behind the beam.
module line_buffer_out
  import line_buffer_out_pkg::*;
#(
  parameter int            WIDTH  = 320,
  parameter int            DW     = 15,
  parameter int            H_LAST = 423,
  parameter int            V_LAST = 261,
  parameter logic [DW-1:0] TRANSP = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pixel,
  input  logic [8:0]    hcnt,
  input  logic [8:0]    vcnt,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          wr_valid,
  input  logic [8:0]    wr_x,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          line_req,
  output logic [8:0]    line_num,
  output logic [DW-1:0] pix_out,
  output logic          pix_valid
);

  localparam int AW = $clog2(WIDTH);

  state_t        state;
  logic [AW-1:0] init_addr;
  logic          rd_sel;
  logic          swap;
  logic          rd_fire;
  logic          wr_accept;
  logic [1:0]    a_en;
  logic [1:0]    b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [DW-1:0] rdata [2];
  logic          rd_q;
  logic          bank_q;
  logic          vis_q;

  assign wr_ready  = (state == RUN);
  assign swap      = wr_ready && ce_pixel && (hcnt == 9'(H_LAST));
  assign rd_fire   = wr_ready && ce_pixel && (hcnt < 9'(WIDTH)) && !vblank;
  assign wr_accept = wr_valid && wr_ready && (wr_x < 9'(WIDTH)) && (wr_data != TRANSP);

  // Bank steering: INIT clears both banks through port B; in RUN the read
  // bank gets the read-clear and the other bank takes renderer writes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    a_en    = '0;
    b_we    = '0;
    b_addr  = wr_x[AW-1:0];
    b_wdata = wr_data;
    if (state == INIT) begin
      b_we    = 2'b11;
      b_addr  = init_addr;
      b_wdata = TRANSP;
    end else begin
      a_en[rd_sel]  = rd_fire;
      b_we[~rd_sel] = wr_accept;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    line_ram #(
      .DEPTH(WIDTH),
      .DW   (DW),
      .AW   (AW)
    ) u_ram (
      .clk    (clk),
      .a_en   (a_en[b]),
      .a_we   (a_en[b]),
      .a_addr (hcnt[AW-1:0]),
      .a_wdata(TRANSP),
      .a_rdata(rdata[b]),
      .b_we   (b_we[b]),
      .b_addr (b_addr),
      .b_wdata(b_wdata)
    );
  end

  // Control FSM: clear sweep after reset, then bank swap and render request
  // at the end of every line.
  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      init_addr <= '0;
      rd_sel    <= 1'b0;
      line_req  <= 1'b0;
      line_num  <= '0;
    end else begin
      case (state)
        INIT: begin
          line_req <= 1'b0;
          if (init_addr == AW'(WIDTH - 1)) begin
            state <= RUN;
          end else begin
            init_addr <= init_addr + AW'(1);
          end
        end
        RUN: begin
          line_req <= swap;
          if (swap) begin
            rd_sel   <= ~rd_sel;
            line_num <= line_after_next(vcnt, 9'(V_LAST));
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Output pipeline: remember what was read on one pixel tick and present it
  // on the next, so the RAM read latency lines up with the pixel clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q      <= 1'b0;
      bank_q    <= 1'b0;
      vis_q     <= 1'b0;
      pix_out   <= TRANSP;
      pix_valid <= 1'b0;
    end else if (wr_ready && ce_pixel) begin
      rd_q      <= rd_fire;
      bank_q    <= rd_sel;
      vis_q     <= !(hblank || vblank);
      pix_valid <= vis_q;
      pix_out   <= (vis_q && rd_q) ? rdata[bank_q] : TRANSP;
    end
  end

endmodule
